// File: rtl/wb_arbiter.sv
// Round-robin Wishbone classic arbiter: one registered grant per cyc burst, combinational bus mux.
// Optional stall timeout with a one-cycle ABORT response is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter #(
  parameter int MASTERS        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [MASTERS-1:0]       i_m_cyc,
  input  logic [MASTERS-1:0]       i_m_stb,
  input  logic [MASTERS-1:0]       i_m_we,
  input  logic [MASTERS-1:0][31:0] i_m_adr,
  input  logic [MASTERS-1:0][31:0] i_m_dat,
  input  logic [MASTERS-1:0][3:0]  i_m_sel,
  output logic [31:0]              o_m_dat,
  output logic [MASTERS-1:0]       o_m_ack,
  output logic                     o_s_cyc,
  output logic                     o_s_stb,
  output logic                     o_s_we,
  output logic [31:0]              o_s_adr,
  output logic [31:0]              o_s_dat,
  output logic [3:0]               o_s_sel,
  input  logic [31:0]              i_s_dat,
  input  logic                     i_s_ack,
  output logic [MASTERS-1:0]       o_grant,
  output logic                     o_timeout
);

  localparam int IW = $clog2(MASTERS);

  if (MASTERS < 2 || MASTERS > 8) begin : g_bad_masters
    $error("wb_arbiter: MASTERS must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      last_q, last_d;

  logic [IW-1:0]      lo_idx, hi_idx, win_idx;
  logic               hi_found;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] stall_q, stall_d;
  logic        timeout_q, timeout_d;
  logic        stalling;
`endif

  // Lowest requester above last wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      if (i_m_cyc[i]) begin
        lo_idx = IW'(i);
      end
      if (i_m_cyc[i] && (IW'(i) > last_q)) begin
        hi_idx   = IW'(i);
        hi_found = 1'b1;
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    o_s_cyc = 1'b0;
    o_s_stb = 1'b0;
    o_s_we  = 1'b0;
    o_s_adr = '0;
    o_s_dat = '0;
    o_s_sel = '0;
    o_m_ack = '0;
    o_m_dat = i_s_dat;
    case (state_q)
      ST_GRANT: begin
        o_s_cyc         = i_m_cyc[gidx_q];
        o_s_stb         = i_m_stb[gidx_q];
        o_s_we          = i_m_we[gidx_q];
        o_s_adr         = i_m_adr[gidx_q];
        o_s_dat         = i_m_dat[gidx_q];
        o_s_sel         = i_m_sel[gidx_q];
        o_m_ack[gidx_q] = i_s_ack & i_m_stb[gidx_q];
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_ABORT: begin
        o_m_ack[gidx_q] = 1'b1;
        o_m_dat         = 32'hDEAD_BEEF;
      end
`endif
      default: ;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  assign stalling = i_m_stb[gidx_q] & ~i_s_ack;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
`ifdef WB_ARB_TIMEOUT_EN
    stall_d   = '0;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|i_m_cyc) begin
          state_d          = ST_GRANT;
          gidx_d           = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!i_m_cyc[gidx_q]) begin
          state_d = ST_IDLE;
          last_d  = gidx_q;
          grant_d = '0;
`ifdef WB_ARB_TIMEOUT_EN
        end else if (stalling && (stall_q == STALL_LAST)) begin
          state_d   = ST_ABORT;
          timeout_d = 1'b1;
        end else begin
          // Counter holds while the master idles its strobe without an ack.
          if (i_s_ack) begin
            stall_d = '0;
          end else if (i_m_stb[gidx_q]) begin
            stall_d = stall_q + 16'd1;
          end else begin
            stall_d = stall_q;
          end
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_ABORT: begin
        state_d = ST_IDLE;
        last_d  = gidx_q;
        grant_d = '0;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_grant = grant_q;
`ifdef WB_ARB_TIMEOUT_EN
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (MASTERS=2, TIMEOUT_CYCLES=4) with a scoreboard of expected slave traffic.
module tb_wb_arbiter;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       m_cyc = '0, m_stb = '0, m_we = '0;
  logic [1:0][31:0] m_adr = '0, m_dat = '0;
  logic [1:0][3:0]  m_sel = '0;
  logic [31:0]      o_m_dat;
  logic [1:0]       o_m_ack;
  logic             o_s_cyc, o_s_stb, o_s_we;
  logic [31:0]      o_s_adr, o_s_dat;
  logic [3:0]       o_s_sel;
  logic [31:0]      s_dat = '0;
  logic             s_ack = 1'b0;
  logic [1:0]       o_grant;
  logic             o_timeout;

  typedef struct {
    int          m;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  logic [31:0] exp_q[$];
  wr_t         wr_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  wb_arbiter #(.MASTERS(2), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
    .o_m_dat(o_m_dat), .o_m_ack(o_m_ack),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_sel(o_s_sel),
    .i_s_dat(s_dat), .i_s_ack(s_ack),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  cnt [2];
    int  total;
    bit  drop [2];
    wr_t e;
    int  g;

    // Reset state
    smp;
    chk("rst_grant", o_grant, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_ack", o_m_ack, 0);
    chk("rst_s_ctl", {o_s_cyc, o_s_stb, o_s_we}, 0);
    chk("rst_s_adr", o_s_adr, 0);
    chk("rst_s_dat", o_s_dat, 0);
    chk("rst_s_sel", o_s_sel, 0);
    tick;
    reset_n = 1'b1;

    // Stray ack while idle
    tick;
    s_ack = 1'b1; s_dat = 32'h0BAD_0BAD;
    smp;
    chk("stray_ack", o_m_ack, 0);
    chk("idle_dat_pass", o_m_dat, 32'h0BAD_0BAD);
    chk("idle_s_cyc", o_s_cyc, 0);

    // Single read by master 0, slave acks two cycles after stb
    tick;
    s_ack = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
    m_adr[0] = 32'h0000_0010; m_sel[0] = 4'hF;
    smp;
    chk("t1_pre_grant", o_grant, 0);
    tick; smp;
    chk("t1_grant", o_grant, 2'b01);
    chk("t1_s_cyc", o_s_cyc, 1);
    chk("t1_s_adr", o_s_adr, 32'h10);
    chk("t1_s_we", o_s_we, 0);
    tick; smp;
    chk("t1_wait_ack", o_m_ack, 0);
    tick;
    s_ack = 1'b1; s_dat = 32'h1234_5678; exp_q.push_back(32'h1234_5678);
    smp;
    chk("t1_ack", o_m_ack, 2'b01);
    pop_chk("t1_rdata", o_m_dat);
    tick;
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    smp;
    chk("t1_release_s_cyc", o_s_cyc, 0);
    chk("t1_release_grant_held", o_grant, 2'b01);
    tick; smp;
    chk("t1_idle_grant", o_grant, 0);

    // Simultaneous requests after reset
    tick; reset_n = 1'b0;
    tick; reset_n = 1'b1;
    tick;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
    m_adr[0] = 32'h0000_0100; m_adr[1] = 32'h0000_0200;
    smp;
    tick; smp;
    chk("t2_grant0", o_grant, 2'b01);
    chk("t2_s_adr0", o_s_adr, 32'h100);
    tick;
    s_ack = 1'b1; s_dat = 32'h1111_1111;
    smp;
    chk("t2_ack_m0_only", o_m_ack, 2'b01);
    tick;
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    smp;
    chk("t2_drop_ack", o_m_ack, 0);
    tick; smp;
    chk("t2_idle_gap", o_grant, 0);
    tick; smp;
    chk("t2_grant1", o_grant, 2'b10);
    chk("t2_s_adr1", o_s_adr, 32'h200);
    tick;
    s_ack = 1'b1;
    smp;
    chk("t2_ack_m1", o_m_ack, 2'b10);
    tick;
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    tick; smp;
    chk("t2_idle", o_grant, 0);

    // Fairness: 8 writes from each master, strict alternation from master 0
    for (int k = 0; k < 8; k++) begin
      for (int m = 0; m < 2; m++) begin
        e.m   = m;
        e.adr = 32'h1000 * (m + 1) + k;
        e.dat = 32'hA0 + k;
        e.sel = 4'b0001 << (k % 4);
        if (m == 1) e.sel = ~e.sel;
        wr_q.push_back(e);
      end
    end
    cnt[0] = 0; cnt[1] = 0; drop[0] = 0; drop[1] = 0; total = 0;
    for (int c = 0; c < 200 && total < 16; c++) begin
      tick;
      s_ack = 1'b0;
      for (int m = 0; m < 2; m++) begin
        logic [3:0] s;
        s = 4'b0001 << (cnt[m] % 4);
        if (m == 1) s = ~s;
        m_cyc[m] = (cnt[m] < 8) && !drop[m];
        m_stb[m] = m_cyc[m];
        m_we[m]  = 1'b1;
        m_adr[m] = 32'h1000 * (m + 1) + cnt[m];
        m_dat[m] = 32'hA0 + cnt[m];
        m_sel[m] = s;
        drop[m]  = 0;
      end
      smp;
      if (o_s_cyc && o_s_stb) begin
        s_ack = 1'b1;
        #1;
        g = o_grant[1] ? 1 : 0;
        if (wr_q.size() == 0) begin
          chk("t3_extra_write", 1, 0);
        end else begin
          e = wr_q.pop_front();
          chk("t3_grant", o_grant, 32'(1) << e.m);
          chk("t3_adr", o_s_adr, e.adr);
          chk("t3_dat", o_s_dat, e.dat);
          chk("t3_sel", o_s_sel, e.sel);
          chk("t3_we", o_s_we, 1);
          chk("t3_ack", o_m_ack, 32'(1) << e.m);
        end
        cnt[g]++;
        drop[g] = 1;
        total++;
      end
    end
    chk("t3_total", total, 16);
    chk("t3_queue_left", wr_q.size(), 0);
    tick;
    s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
    tick; tick; smp;
    chk("t3_idle", o_grant, 0);

    // Reset while the slave stalls a read
    tick;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h20; m_sel[0] = 4'hF;
    smp;
    tick; smp;
    chk("t4_grant", o_grant, 2'b01);
    tick; smp;
    #1 reset_n = 1'b0;
    #1;
    chk("t4_rst_grant", o_grant, 0);
    chk("t4_rst_s_ctl", {o_s_cyc, o_s_stb, o_s_we}, 0);
    chk("t4_rst_s_adr", o_s_adr, 0);
    chk("t4_rst_ack", o_m_ack, 0);
    chk("t4_rst_timeout", o_timeout, 0);
    tick;
    m_cyc = '0; m_stb = '0;
    tick;
    reset_n = 1'b1;
    tick;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h30; m_sel[1] = 4'h3;
    smp;
    chk("t4_pre_grant", o_grant, 0);
    tick; smp;
    chk("t4_grant_m1", o_grant, 2'b10);
    chk("t4_s_adr", o_s_adr, 32'h30);
    s_ack = 1'b1;
    #1;
    chk("t4_ack_m1", o_m_ack, 2'b10);
    tick;
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    tick; smp;
    chk("t4_idle", o_grant, 0);

    // Stalled slave: abort after 4 stall cycles, or hang when the timeout is compiled out
    tick;
    s_dat = 32'h5555_5555;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h40;
`ifdef WB_ARB_TIMEOUT_EN
    exp_q.push_back(32'hDEAD_BEEF);
`endif
    smp;
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick; smp;
      chk("t5_stall_grant", o_grant, 2'b01);
      chk("t5_stall_s_cyc", o_s_cyc, 1);
      chk("t5_stall_ack", o_m_ack, 0);
      chk("t5_stall_timeout", o_timeout, 0);
    end
    tick; smp;
    chk("t5_abort_ack", o_m_ack, 2'b01);
    pop_chk("t5_abort_dat", o_m_dat);
    chk("t5_abort_timeout", o_timeout, 1);
    chk("t5_abort_s_cyc", o_s_cyc, 0);
    chk("t5_abort_s_stb", o_s_stb, 0);
    tick;
    m_cyc = '0; m_stb = '0;
    smp;
    chk("t5_idle_grant", o_grant, 0);
    chk("t5_idle_timeout", o_timeout, 0);
    chk("t5_idle_ack", o_m_ack, 0);
`else
    for (int i = 0; i < 1000; i++) begin
      tick; smp;
      chk("t6_hold_grant", o_grant, 2'b01);
      chk("t6_hold_timeout", o_timeout, 0);
      chk("t6_hold_ack", o_m_ack, 0);
    end
    tick;
    m_cyc = '0; m_stb = '0;
    tick; smp;
    chk("t6_idle_grant", o_grant, 0);
`endif
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
